// File: rtl/waterled_multi_if.sv
// Control and LED-drive bundle for the running-light controller.
// The host/board side is master; waterled_multi is slave.
interface waterled_multi_if #(
    parameter int LED_NUM = 8
);
    logic               enable;
    logic [1:0]         mode;
    logic [1:0]         speed_sel;
    logic [LED_NUM-1:0] led_out;
    logic               step_pulse;
    logic               dir;

    modport master (
        output enable, mode, speed_sel,
        input  led_out, step_pulse, dir
    );

    modport slave (
        input  enable, mode, speed_sel,
        output led_out, step_pulse, dir
    );
endinterface

// File: rtl/waterled_multi.sv
// Running-light controller: prescaled step tick walks one lit LED (up/down/ping-pong/hold).
// Optional head+tail trail enabled by defining WATERLED_TRAIL_EN.
module waterled_multi #(
    parameter int LED_NUM    = 8,
    parameter int CNT_WIDTH  = 25,
    parameter int STEP_MAX   = 24_999_999,
    parameter int ACTIVE_LOW = 1
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    waterled_multi_if.slave  bus
);
    localparam int                   POS_W      = $clog2(LED_NUM);
    localparam logic [POS_W-1:0]     POS_LAST   = POS_W'(LED_NUM - 1);
    localparam logic [POS_W-1:0]     POS_ONE    = POS_W'(1);
    localparam logic [CNT_WIDTH-1:0] STEP_MAX_C = CNT_WIDTH'(STEP_MAX);

    // Head and tail share one LED when no trail is shown, so a single helper covers both builds.
    function automatic logic [LED_NUM-1:0] led_pattern(
        input logic [POS_W-1:0] head,
        input logic [POS_W-1:0] tail
    );
        logic [LED_NUM-1:0] lit;
        lit = (LED_NUM'(1) << head) | (LED_NUM'(1) << tail);
        return (ACTIVE_LOW != 0) ? ~lit : lit;
    endfunction

    logic [CNT_WIDTH-1:0] cnt_r;
    logic [POS_W-1:0]     pos_r;
    logic                 dir_r;
    logic                 step_pulse_r;
    logic [LED_NUM-1:0]   led_r;

    logic [CNT_WIDTH-1:0] eff_max_s;
    logic                 tick_s;
    logic [POS_W-1:0]     pos_nxt_s;
    logic                 dir_nxt_s;
    logic [POS_W-1:0]     tail_nxt_s;

    // Prescaler terminal compare; ">=" lets a shortened period take effect immediately.
    always_comb begin
        eff_max_s = STEP_MAX_C >> bus.speed_sel;
        tick_s    = bus.enable && (cnt_r >= eff_max_s);
    end

    // Next head position and ping-pong direction for the current mode.
    always_comb begin
        pos_nxt_s = pos_r;
        dir_nxt_s = dir_r;
        case (bus.mode)
            2'b00: pos_nxt_s = (pos_r == POS_LAST) ? '0 : pos_r + POS_ONE;
            2'b01: pos_nxt_s = (pos_r == '0) ? POS_LAST : pos_r - POS_ONE;
            2'b10: begin
                if (dir_r) begin
                    if (pos_r == POS_LAST) begin
                        pos_nxt_s = pos_r - POS_ONE;
                        dir_nxt_s = 1'b0;
                    end else begin
                        pos_nxt_s = pos_r + POS_ONE;
                    end
                end else begin
                    if (pos_r == '0) begin
                        pos_nxt_s = pos_r + POS_ONE;
                        dir_nxt_s = 1'b1;
                    end else begin
                        pos_nxt_s = pos_r - POS_ONE;
                    end
                end
            end
            2'b11:   pos_nxt_s = pos_r;
            default: pos_nxt_s = pos_r;
        endcase
    end

`ifdef WATERLED_TRAIL_EN
    logic [POS_W-1:0] prev_pos_r;

    // Tail follows the old head only when the head actually moves.
    always_comb begin
        if (tick_s && (pos_nxt_s != pos_r)) begin
            tail_nxt_s = pos_r;
        end else begin
            tail_nxt_s = prev_pos_r;
        end
    end

    // Trail position register.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            prev_pos_r <= '0;
        end else begin
            prev_pos_r <= tail_nxt_s;
        end
    end
`else
    // Without a trail the tail coincides with the head.
    always_comb begin
        tail_nxt_s = pos_nxt_s;
    end
`endif

    // Prescaler, position, direction, strobe and registered LED drive.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            cnt_r        <= '0;
            pos_r        <= '0;
            dir_r        <= 1'b1;
            step_pulse_r <= 1'b0;
            led_r        <= led_pattern('0, '0);
        end else begin
            step_pulse_r <= tick_s;
            if (bus.enable) begin
                cnt_r <= tick_s ? '0 : cnt_r + CNT_WIDTH'(1);
            end
            if (tick_s) begin
                pos_r <= pos_nxt_s;
                dir_r <= dir_nxt_s;
                led_r <= led_pattern(pos_nxt_s, tail_nxt_s);
            end
        end
    end

    assign bus.led_out    = led_r;
    assign bus.step_pulse = step_pulse_r;
    assign bus.dir        = dir_r;
endmodule

// File: tb/tb_waterled_multi.sv
// Randomized scoreboard bench for waterled_multi (LED_NUM=8, STEP_MAX=3, active-low).
module tb_waterled_multi;
    localparam int N        = 8;
    localparam int STEP_MAX = 3;

    typedef struct packed {
        logic [N-1:0] led;
        logic         pulse;
        logic         dir;
    } exp_t;

    logic sys_clk;
    logic sys_rst;
    waterled_multi_if #(.LED_NUM(N)) bus ();

    waterled_multi #(
        .LED_NUM(N), .CNT_WIDTH(4), .STEP_MAX(STEP_MAX), .ACTIVE_LOW(1)
    ) dut (
        .sys_clk(sys_clk),
        .sys_rst(sys_rst),
        .bus(bus)
    );

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    // reference model state
    int m_cnt  = 0;
    int m_pos  = 0;
    int m_prev = 0;
    int m_dir  = 1;

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not complete within time limit");
        $fatal(1, "watchdog");
    end

    // Drive inputs, advance the model by one clock edge, queue the expected outputs.
    task automatic apply(input logic rst, input logic en, input logic [1:0] md, input logic [1:0] spd);
        exp_t e;
        int   eff;
        int   old;
        logic tick;
        logic [N-1:0] lit;
        sys_rst       = rst;
        bus.enable    = en;
        bus.mode      = md;
        bus.speed_sel = spd;
        tick = 1'b0;
        if (rst) begin
            m_cnt = 0; m_pos = 0; m_prev = 0; m_dir = 1;
        end else if (en) begin
            eff = STEP_MAX >> spd;
            if (m_cnt >= eff) begin
                m_cnt = 0;
                tick  = 1'b1;
            end else begin
                m_cnt = m_cnt + 1;
            end
        end
        if (tick) begin
            old = m_pos;
            case (md)
                2'd0: m_pos = (m_pos + 1) % N;
                2'd1: m_pos = (m_pos + N - 1) % N;
                2'd2: begin
                    if (m_dir == 1 && m_pos == N - 1) m_dir = 0;
                    else if (m_dir == 0 && m_pos == 0) m_dir = 1;
                    m_pos = (m_dir == 1) ? m_pos + 1 : m_pos - 1;
                end
                default: m_pos = m_pos;
            endcase
            if (m_pos != old) m_prev = old;
        end
        lit = N'(1) << m_pos;
`ifdef WATERLED_TRAIL_EN
        lit = lit | (N'(1) << m_prev);
`endif
        e.led   = ~lit;
        e.pulse = tick;
        e.dir   = (m_dir != 0);
        exp_q.push_back(e);
    endtask

    // Monitor: every clock edge produces one output sample to score.
    initial begin
        exp_t e;
        forever begin
            @(posedge sys_clk);
            #1;
            cyc++;
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL underflow cyc=%0d: no expected entry queued", cyc);
            end else begin
                e = exp_q.pop_front();
                total++;
                if (bus.led_out !== e.led) begin
                    bad++;
                    $display("FAIL led_out cyc=%0d got=%h want=%h", cyc, bus.led_out, e.led);
                end
                total++;
                if (bus.step_pulse !== e.pulse) begin
                    bad++;
                    $display("FAIL step_pulse cyc=%0d got=%b want=%b", cyc, bus.step_pulse, e.pulse);
                end
                total++;
                if (bus.dir !== e.dir) begin
                    bad++;
                    $display("FAIL dir cyc=%0d got=%b want=%b", cyc, bus.dir, e.dir);
                end
            end
        end
    end

    // Stimulus: directed opening phases, then randomized phases with mid-phase tweaks.
    initial begin
        logic       en;
        logic [1:0] md;
        logic [1:0] spd;
        apply(1'b1, 1'b0, 2'd0, 2'd0);
        repeat (2) begin @(negedge sys_clk); apply(1'b1, 1'b0, 2'd0, 2'd0); end
        repeat (40) begin @(negedge sys_clk); apply(1'b0, 1'b1, 2'd0, 2'd0); end
        repeat (40) begin @(negedge sys_clk); apply(1'b0, 1'b1, 2'd1, 2'd0); end
        repeat (80) begin @(negedge sys_clk); apply(1'b0, 1'b1, 2'd2, 2'd0); end
        repeat (10) begin @(negedge sys_clk); apply(1'b0, 1'b0, 2'd2, 2'd0); end
        repeat (20) begin @(negedge sys_clk); apply(1'b0, 1'b1, 2'd2, 2'd1); end
        repeat (3)  begin @(negedge sys_clk); apply(1'b1, 1'b1, 2'd2, 2'd0); end
        repeat (12) begin @(negedge sys_clk); apply(1'b0, 1'b1, 2'd3, 2'd0); end
        for (int ph = 0; ph < 80; ph++) begin
            md  = 2'($urandom_range(0, 3));
            spd = 2'($urandom_range(0, 3));
            en  = ($urandom_range(0, 4) != 0);
            for (int k = 0, len = $urandom_range(10, 50); k < len; k++) begin
                if ($urandom_range(0, 15) == 0) spd = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 20) == 0) en = ~en;
                @(negedge sys_clk);
                apply(($urandom_range(0, 60) == 0), en, md, spd);
            end
        end
        @(posedge sys_clk);
        #2;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
